// File: rtl/video_pattern_gen.sv
// Raster test-pattern source: emits a sample strobe, {F,V,H,T} timing and
// 4:2:2 {Y,C} samples for colour bars, a flat colour, a luma ramp or black.
module video_pattern_gen #(
  parameter int H_ACTIVE   = 1920,
  parameter int H_TOTAL    = 2200,
  parameter int V_ACTIVE   = 1080,
  parameter int V_TOTAL    = 1125,
  parameter int CEN_DIV    = 2,
  parameter int RAMP_SHIFT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [1:0]  pat_sel_i,
  input  logic [9:0]  flat_y_i,
  input  logic [9:0]  flat_cb_i,
  input  logic [9:0]  flat_cr_i,
  output logic        cen_o,
  output logic [3:0]  fvht_o,
  output logic [19:0] video_o
);

  localparam int HW    = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW    = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int DW    = (CEN_DIV > 1) ? $clog2(CEN_DIV) : 1;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int RW    = (HW > 12) ? HW + 1 : 13;

  localparam logic [9:0] BLANK_Y = 10'd64;
  localparam logic [9:0] BLANK_C = 10'd512;

  logic [DW-1:0] div_q;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          f_q;
  logic [2:0]    bar_idx;
  logic [BW-1:0] bar_sub;
  logic [1:0]    pat_q;
  logic [9:0]    flat_y_q, flat_cb_q, flat_cr_q;

  logic          vld_p0;
  logic          frame_start;
  logic          h_last, v_last;
  logic [1:0]    use_pat;
  logic [9:0]    use_y, use_cb, use_cr;
  logic [3:0]    fvht_p0;
  logic [19:0]   vid_p0;

  // 75% bar colours; odd samples carry Cr, even samples carry Cb.
  function automatic logic [19:0] bar_px(input logic [2:0] idx, input logic cr_ph);
    logic [9:0] y, cb, cr;
    case (idx)
      3'd0:    begin y = 10'd721; cb = 10'd512; cr = 10'd512; end
      3'd1:    begin y = 10'd674; cb = 10'd176; cr = 10'd543; end
      3'd2:    begin y = 10'd581; cb = 10'd589; cr = 10'd176; end
      3'd3:    begin y = 10'd534; cb = 10'd253; cr = 10'd207; end
      3'd4:    begin y = 10'd251; cb = 10'd771; cr = 10'd817; end
      3'd5:    begin y = 10'd204; cb = 10'd435; cr = 10'd848; end
      3'd6:    begin y = 10'd111; cb = 10'd848; cr = 10'd481; end
      default: begin y = 10'd64;  cb = 10'd512; cr = 10'd512; end
    endcase
    return {y, cr_ph ? cr : cb};
  endfunction

  // Ramp luma: 64 + (h >> RAMP_SHIFT), saturated at the nominal white of 940.
  function automatic logic [9:0] ramp_y(input logic [HW-1:0] h);
    logic [RW-1:0] s;
    s = RW'(h) >> RAMP_SHIFT;
    if (s > RW'(876)) return 10'd940;
    return 10'(s + RW'(64));
  endfunction

  // Stage 0: sample content derived from the current raster position
  always_comb begin
    vld_p0      = en_i && (div_q == '0);
    frame_start = (h_cnt == '0) && (v_cnt == '0);
    h_last      = (h_cnt == HW'(H_TOTAL - 1));
    v_last      = (v_cnt == VW'(V_TOTAL - 1));
    use_pat     = frame_start ? pat_sel_i : pat_q;
    use_y       = frame_start ? flat_y_i  : flat_y_q;
    use_cb      = frame_start ? flat_cb_i : flat_cb_q;
    use_cr      = frame_start ? flat_cr_i : flat_cr_q;
    fvht_p0     = {f_q, (v_cnt >= VW'(V_ACTIVE)), (h_cnt >= HW'(H_ACTIVE)), (h_cnt == '0)};
    vid_p0      = {BLANK_Y, BLANK_C};
    if (!fvht_p0[2] && !fvht_p0[1]) begin
      case (use_pat)
        2'd0:    vid_p0 = bar_px(bar_idx, h_cnt[0]);
        2'd1:    vid_p0 = {use_y, h_cnt[0] ? use_cr : use_cb};
        2'd2:    vid_p0 = {ramp_y(h_cnt), BLANK_C};
        default: vid_p0 = {BLANK_Y, BLANK_C};
      endcase
    end
  end

  // Stage 1: divider, raster counters, frame-start latch and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q     <= '0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      f_q       <= 1'b0;
      bar_idx   <= '0;
      bar_sub   <= '0;
      pat_q     <= '0;
      flat_y_q  <= '0;
      flat_cb_q <= '0;
      flat_cr_q <= '0;
      cen_o     <= 1'b0;
      fvht_o    <= 4'h0;
      video_o   <= {BLANK_Y, BLANK_C};
    end else if (!en_i) begin
      div_q   <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      f_q     <= 1'b0;
      bar_idx <= '0;
      bar_sub <= '0;
      cen_o   <= 1'b0;
      fvht_o  <= 4'h0;
      video_o <= {BLANK_Y, BLANK_C};
    end else begin
      div_q <= (div_q == DW'(CEN_DIV - 1)) ? '0 : div_q + 1'b1;
      cen_o <= vld_p0;
      if (vld_p0) begin
        fvht_o  <= fvht_p0;
        video_o <= vid_p0;
        if (frame_start) begin
          pat_q     <= pat_sel_i;
          flat_y_q  <= flat_y_i;
          flat_cb_q <= flat_cb_i;
          flat_cr_q <= flat_cr_i;
        end
        if (h_last) begin
          h_cnt   <= '0;
          bar_idx <= '0;
          bar_sub <= '0;
          if (v_last) begin
            v_cnt <= '0;
            f_q   <= ~f_q;
          end else begin
            v_cnt <= v_cnt + 1'b1;
          end
        end else begin
          h_cnt <= h_cnt + 1'b1;
          if (bar_sub == BW'(BAR_W - 1)) begin
            bar_sub <= '0;
            bar_idx <= bar_idx + 1'b1;
          end else begin
            bar_sub <= bar_sub + 1'b1;
          end
        end
      end
    end
  end

endmodule
